// File: rtl/banner_sequencer.sv
// banner_sequencer
// Picks the highest-priority pending banner request and animates it:
// slide down to the rest row, hold while blinking, then slide back out.
// Every visible output changes only on a frame_tick edge, so a banner
// never tears in the middle of a frame.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no banner shown, waiting for a pending request on a tick
// SLIDE_IN   | moving down by SLIDE_STEP per tick, clamped at Y_TARGET
// HOLD       | parked at Y_TARGET for FRAME_HOLD ticks, text blinks
// SLIDE_OUT  | moving up by SLIDE_STEP per tick, clamped at Y_START
//
// A request with a higher index than the banner on screen preempts it
// from any non-idle state and restarts SLIDE_IN from the current row.
// FRAME_HOLD must be at least 1.

module banner_sequencer #(
    parameter int NUM_MSG    = 4,
    parameter int Y_START    = 0,
    parameter int Y_TARGET   = 96,
    parameter int SLIDE_STEP = 8,
    parameter int FRAME_HOLD = 60,
    parameter int BLINK_HALF = 15,
    localparam int SEL_W     = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1
) (
    input  logic               clk_0,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic [NUM_MSG-1:0] req,
    output logic [SEL_W-1:0]   msg_sel,
    output logic [9:0]         y_pos,
    output logic               text_en,
    output logic               busy,
    output logic               done
);

    localparam int HOLD_W  = (FRAME_HOLD < 2) ? 1 : $clog2(FRAME_HOLD + 1);
    localparam int BLINK_W = (BLINK_HALF < 2) ? 1 : $clog2(BLINK_HALF + 1);

    localparam logic [9:0]         Y_START_V  = 10'(Y_START);
    localparam logic [9:0]         Y_TARGET_V = 10'(Y_TARGET);
    localparam logic [10:0]        STEP_V     = 11'(SLIDE_STEP);
    localparam logic [10:0]        Y_FLOOR_V  = 11'(Y_START + SLIDE_STEP);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(FRAME_HOLD);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SLIDE_IN,
        ST_HOLD,
        ST_SLIDE_OUT
    } state_t;

    state_t               r_state;
    logic [NUM_MSG-1:0]   r_pending;
    logic [SEL_W-1:0]     r_msg_sel;
    logic [9:0]           r_y_pos;
    logic                 r_text_en;
    logic                 r_busy;
    logic                 r_done;
    logic [HOLD_W-1:0]    r_hold_cnt;
    logic [BLINK_W-1:0]   r_blink_cnt;

    logic                 w_any;
    logic [SEL_W-1:0]     w_cand;
    logic                 w_accept;
    logic [NUM_MSG-1:0]   w_clr_mask;
    logic [10:0]          w_y_up;
    logic [9:0]           w_y_in_next;
    logic [9:0]           w_y_out_next;
    logic [HOLD_W-1:0]    w_hold_inc;
    logic [BLINK_W-1:0]   w_blink_inc;

    // Priority encoder: the highest set pending bit is the candidate.
    always_comb begin
        w_cand = '0;
        w_any  = 1'b0;
        for (int i = 0; i < NUM_MSG; i++) begin
            if (r_pending[i]) begin
                w_cand = SEL_W'(i);
                w_any  = 1'b1;
            end
        end
    end

    // Accept from IDLE, or preempt only with a strictly higher index.
    assign w_accept   = frame_tick && w_any &&
                        ((r_state == ST_IDLE) || (w_cand > r_msg_sel));
    assign w_clr_mask = w_accept ? (NUM_MSG'(1) << w_cand) : '0;

    // Slide arithmetic is done one bit wider / guarded so it cannot wrap.
    assign w_y_up       = {1'b0, r_y_pos} + STEP_V;
    assign w_y_in_next  = (w_y_up >= {1'b0, Y_TARGET_V}) ? Y_TARGET_V : w_y_up[9:0];
    assign w_y_out_next = ({1'b0, r_y_pos} >= Y_FLOOR_V) ? (r_y_pos - STEP_V[9:0])
                                                         : Y_START_V;

    assign w_hold_inc  = r_hold_cnt + HOLD_W'(1);
    assign w_blink_inc = r_blink_cnt + BLINK_W'(1);

    // Latch request pulses; a same-cycle request beats the accept clear.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | req;
        end
    end

    // Banner FSM; all visible outputs are updated only on frame_tick.
    always_ff @(posedge clk_0) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_msg_sel   <= '0;
            r_y_pos     <= Y_START_V;
            r_text_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_hold_cnt  <= '0;
            r_blink_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            if (frame_tick) begin
                if (w_accept) begin
                    r_msg_sel   <= w_cand;
                    r_text_en   <= 1'b1;
                    r_hold_cnt  <= '0;
                    r_blink_cnt <= '0;
                    r_busy      <= 1'b1;
                    r_state     <= ST_SLIDE_IN;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            r_busy <= 1'b0;
                        end
                        ST_SLIDE_IN: begin
                            r_y_pos <= w_y_in_next;
                            if (w_y_in_next == Y_TARGET_V) begin
                                r_hold_cnt  <= '0;
                                r_blink_cnt <= '0;
                                r_state     <= ST_HOLD;
                            end
                        end
                        ST_HOLD: begin
                            r_hold_cnt <= w_hold_inc;
                            if (BLINK_HALF != 0) begin
                                if (w_blink_inc == BLINK_LAST) begin
                                    r_text_en   <= ~r_text_en;
                                    r_blink_cnt <= '0;
                                end else begin
                                    r_blink_cnt <= w_blink_inc;
                                end
                            end
                            // End of hold wins over a blink toggle on the same tick.
                            if (w_hold_inc == HOLD_LAST) begin
                                r_text_en   <= 1'b1;
                                r_hold_cnt  <= '0;
                                r_blink_cnt <= '0;
                                r_state     <= ST_SLIDE_OUT;
                            end
                        end
                        ST_SLIDE_OUT: begin
                            r_y_pos <= w_y_out_next;
                            if (w_y_out_next == Y_START_V) begin
                                r_text_en <= 1'b0;
                                r_done    <= 1'b1;
                                r_busy    <= 1'b0;
                                r_state   <= ST_IDLE;
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign msg_sel = r_msg_sel;
    assign y_pos   = r_y_pos;
    assign text_en = r_text_en;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_banner_sequencer.sv
// Randomized scoreboard bench for banner_sequencer. Two instances run on
// the same stimulus: one with default parameters, one with a 7-pixel step,
// a short hold and blinking disabled.
module tb_banner_sequencer;

    logic       clk_0 = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic [3:0] req;

    logic [1:0] sel0, sel1;
    logic [9:0] y0, y1;
    logic       ten0, ten1, busy0, busy1, done0, done1;

    always #5 clk_0 = ~clk_0;

    banner_sequencer u_dut0 (
        .clk_0(clk_0), .rst(rst), .frame_tick(frame_tick), .req(req),
        .msg_sel(sel0), .y_pos(y0), .text_en(ten0), .busy(busy0), .done(done0)
    );

    banner_sequencer #(.SLIDE_STEP(7), .FRAME_HOLD(20), .BLINK_HALF(0)) u_dut1 (
        .clk_0(clk_0), .rst(rst), .frame_tick(frame_tick), .req(req),
        .msg_sel(sel1), .y_pos(y1), .text_en(ten1), .busy(busy1), .done(done1)
    );

    typedef struct packed {
        logic [1:0] sel;
        logic [9:0] y;
        logic       ten;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase 0 idle, 1 sliding in, 2 holding, 3 sliding out.
    int         m_phase[2];
    int         m_y[2];
    int         m_hold[2];
    int         m_sel[2];
    logic       m_ten[2];
    logic       m_done[2];
    logic [3:0] m_pend[2];

    task automatic model_cycle(input int k, input logic tick, input logic [3:0] rq,
                               input logic rstn);
        int step, fh, bh, cand, acc;
        step = (k == 0) ? 8 : 7;
        fh   = (k == 0) ? 60 : 20;
        bh   = (k == 0) ? 15 : 0;
        if (!rstn) begin
            m_phase[k] = 0; m_y[k] = 0; m_hold[k] = 0; m_sel[k] = 0;
            m_ten[k] = 1'b0; m_done[k] = 1'b0; m_pend[k] = 4'b0;
            return;
        end
        m_done[k] = 1'b0;
        cand = -1;
        for (int i = 0; i < 4; i++) if (m_pend[k][i]) cand = i;
        acc = -1;
        if (tick) begin
            if (cand >= 0 && (m_phase[k] == 0 || cand > m_sel[k])) begin
                m_sel[k] = cand; m_phase[k] = 1; m_ten[k] = 1'b1; m_hold[k] = 0;
                acc = cand;
            end else if (m_phase[k] == 1) begin
                m_y[k] = (m_y[k] + step > 96) ? 96 : m_y[k] + step;
                if (m_y[k] == 96) begin m_phase[k] = 2; m_hold[k] = 0; end
            end else if (m_phase[k] == 2) begin
                m_hold[k]++;
                if (m_hold[k] == fh) begin
                    m_ten[k] = 1'b1; m_phase[k] = 3;
                end else begin
                    m_ten[k] = (bh == 0) ? 1'b1 : (((m_hold[k] / bh) % 2) == 0);
                end
            end else if (m_phase[k] == 3) begin
                m_y[k] = (m_y[k] - step < 0) ? 0 : m_y[k] - step;
                if (m_y[k] == 0) begin m_ten[k] = 1'b0; m_done[k] = 1'b1; m_phase[k] = 0; end
            end
        end
        if (acc >= 0) m_pend[k][acc] = 1'b0;
        m_pend[k] = m_pend[k] | rq;
    endtask

    function automatic exp_t model_out(input int k);
        exp_t e;
        e.sel  = 2'(m_sel[k]);
        e.y    = 10'(m_y[k]);
        e.ten  = m_ten[k];
        e.busy = (m_phase[k] != 0);
        e.done = m_done[k];
        return e;
    endfunction

    task automatic compare(input int k, input exp_t e, input exp_t a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL out%0d t=%0t: got sel=%0d y=%0d ten=%0b busy=%0b done=%0b, expected sel=%0d y=%0d ten=%0b busy=%0b done=%0b",
                     k, $time, a.sel, a.y, a.ten, a.busy, a.done,
                     e.sel, e.y, e.ten, e.busy, e.done);
        end
    endtask

    // Monitor: one expected entry per clock, checked 1 ns after the edge.
    always @(posedge clk_0) begin
        #1;
        if (q0.size() > 0) compare(0, q0.pop_front(), {sel0, y0, ten0, busy0, done0});
        if (q1.size() > 0) compare(1, q1.pop_front(), {sel1, y1, ten1, busy1, done1});
    end

    // Stimulus: randomized frame gaps, sparse request pulses, rare resets.
    initial begin
        int         gap;
        logic       tk;
        logic [3:0] rq;
        logic       rn;
        rst = 1'b0; frame_tick = 1'b0; req = 4'b0;
        gap = 2;
        for (int cyc = 0; cyc < 30000; cyc++) begin
            @(negedge clk_0);
            rn = (cyc < 3) ? 1'b0 : ($urandom_range(0, 2499) != 0);
            if (gap == 0) begin
                tk  = 1'b1;
                gap = $urandom_range(1, 4);
            end else begin
                tk = 1'b0;
                gap--;
            end
            rq = 4'b0;
            if (cyc == 5) rq = 4'b1010;
            else if ($urandom_range(0, 119) == 0) rq = 4'($urandom_range(1, 15));
            else if (tk && $urandom_range(0, 19) == 0) rq = 4'($urandom_range(1, 15));
            rst = rn; frame_tick = tk; req = rq;
            model_cycle(0, tk, rq, rn);
            model_cycle(1, tk, rq, rn);
            q0.push_back(model_out(0));
            q1.push_back(model_out(1));
        end
        @(negedge clk_0);
        frame_tick = 1'b0; req = 4'b0;
        repeat (3) @(negedge clk_0);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d/%0d entries left, expected 0/0",
                     q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
